// File: rtl/sram_23k640_slave.sv
// SPI mode-0 responder modelling a 23K640-class serial SRAM (READ/WRITE/RDSR/WRSR).
// Define SRAM_23K640_SLAVE_BACKDOOR_EN to add a parallel preload/inspect port on the array.
module sram_23k640_slave #(
  parameter int AW          = 13,
  parameter int PAGE_AW     = 5,
  parameter int SYNC_STAGES = 2
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_sck,
  input  logic          i_cs,
  input  logic          i_si,
`ifdef SRAM_23K640_SLAVE_BACKDOOR_EN
  input  logic          i_bd_we,
  input  logic [AW-1:0] i_bd_addr,
  input  logic [7:0]    i_bd_wdata,
  output logic [7:0]    o_bd_rdata,
`endif
  output logic          o_so,
  output logic [1:0]    o_mode,
  output logic          o_busy
);

  typedef enum logic [2:0] {
    IDLE, CMD, ADDR, WR_DATA,
    RD_DATA, RDSR, WRSR, IGNORE
  } state_t;

  // input shifter only needs enough history for the kept address bits
  localparam int SW = (AW > 8) ? AW - 1 : 7;
  localparam logic [AW-1:0]      A_ONE = 1;
  localparam logic [PAGE_AW-1:0] P_ONE = 1;

  logic [SYNC_STAGES-1:0] sck_q;
  logic [SYNC_STAGES-1:0] cs_q;
  logic [SYNC_STAGES-1:0] si_q;
  logic                   sck_s, cs_s, si_s;
  logic                   sck_d, cs_d;
  logic                   rise, fall, cs_fall;

  state_t        state, nstate;
  logic [3:0]    bit_cnt;
  logic          last;
  logic [SW-1:0] sh_in;
  logic [SW:0]   rx;
  logic [7:0]    sh_out;
  logic [AW-1:0] addr, adv;
  logic [1:0]    mode;
  logic          byte_mode;
  logic          is_rd;
  logic          spi_we;
  logic [7:0]    status;

  logic [7:0] mem [2**AW];

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      sck_q <= '0;
      cs_q  <= '1;
      si_q  <= '0;
      sck_d <= 1'b0;
      cs_d  <= 1'b1;
    end else begin
      sck_q[0] <= i_sck;
      cs_q[0]  <= i_cs;
      si_q[0]  <= i_si;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        sck_q[i] <= sck_q[i-1];
        cs_q[i]  <= cs_q[i-1];
        si_q[i]  <= si_q[i-1];
      end
      sck_d <= sck_s;
      cs_d  <= cs_s;
    end
  end

  assign sck_s   = sck_q[SYNC_STAGES-1];
  assign cs_s    = cs_q[SYNC_STAGES-1];
  assign si_s    = si_q[SYNC_STAGES-1];
  assign rise    = sck_s & ~sck_d;
  assign fall    = ~sck_s & sck_d;
  assign cs_fall = ~cs_s & cs_d;

  assign rx        = {sh_in, si_s};
  assign status    = {mode, 6'b000010};
  assign byte_mode = (mode[1] == mode[0]);
  assign last      = rise &
    (bit_cnt == ((state == ADDR) ? 4'd15 : 4'd7));
  assign spi_we    = ~cs_s & last & (state == WR_DATA);

  always_comb begin
    adv = addr;
    case (mode)
      2'b10: adv = {addr[AW-1:PAGE_AW],
                    addr[PAGE_AW-1:0] + P_ONE};
      2'b01: adv = addr + A_ONE;
      default: adv = addr;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) state <= IDLE;
    else       state <= nstate;
  end

  always_comb begin
    nstate = state;
    if (cs_s) begin
      nstate = IDLE;
    end else begin
      case (state)
        IDLE: if (cs_fall) nstate = CMD;
        CMD: if (last) begin
          case (rx[7:0])
            8'h03, 8'h02: nstate = ADDR;
            8'h05:        nstate = RDSR;
            8'h01:        nstate = WRSR;
            default:      nstate = IGNORE;
          endcase
        end
        ADDR: if (last) nstate = is_rd ? RD_DATA : WR_DATA;
        WR_DATA, RD_DATA:
          if (last && byte_mode) nstate = IGNORE;
        WRSR: if (last) nstate = IGNORE;
        default: nstate = state;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      bit_cnt <= '0;
      sh_in   <= '0;
      sh_out  <= '0;
      addr    <= '0;
      mode    <= 2'b00;
      is_rd   <= 1'b0;
      o_so    <= 1'b0;
    end else if (cs_s) begin
      bit_cnt <= '0;
      o_so    <= 1'b0;
    end else begin
      if (rise && state != IDLE && state != IGNORE) begin
        sh_in   <= rx[SW-1:0];
        bit_cnt <= last ? 4'd0 : bit_cnt + 4'd1;
        case (state)
          CMD: if (last) begin
            is_rd <= (rx[7:0] == 8'h03);
            if (rx[7:0] == 8'h05) sh_out <= status;
          end
          ADDR: if (last) begin
            addr   <= rx[AW-1:0];
            sh_out <= mem[rx[AW-1:0]];
          end
          WR_DATA: if (last) addr <= adv;
          // prefetch so the next byte's MSB is ready for the coming fall
          RD_DATA: if (last) begin
            addr   <= adv;
            sh_out <= mem[adv];
          end
          RDSR: if (last) sh_out <= status;
          WRSR: if (last) mode <= rx[7:6];
          default: ;
        endcase
      end
      if (fall) begin
        if (state == RD_DATA || state == RDSR) begin
          o_so   <= sh_out[7];
          sh_out <= {sh_out[6:0], 1'b0};
        end else begin
          o_so <= 1'b0;
        end
      end
    end
  end

  always_ff @(posedge i_clk) begin
`ifdef SRAM_23K640_SLAVE_BACKDOOR_EN
    if (i_bd_we && !(spi_we && i_bd_addr == addr))
      mem[i_bd_addr] <= i_bd_wdata;
`endif
    if (spi_we) mem[addr] <= rx[7:0];
  end

`ifdef SRAM_23K640_SLAVE_BACKDOOR_EN
  always_ff @(posedge i_clk) begin
    if (i_rst) o_bd_rdata <= '0;
    else       o_bd_rdata <= mem[i_bd_addr];
  end
`endif

  assign o_mode = mode;
  assign o_busy = (state != IDLE);

endmodule

// File: tb/tb_sram_23k640_slave.sv
// Bench for sram_23k640_slave: bit-banged SPI master against a byte-array model.
module tb_sram_23k640_slave;

  typedef logic [7:0] bq_t [$];

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       sck = 1'b0;
  logic       cs  = 1'b1;
  logic       si  = 1'b0;
  logic       so;
  logic [1:0] mode;
  logic       busy;

  int n_tests = 0;
  int n_fail  = 0;

  logic [7:0] mem_ref [8192];
  logic [1:0] mode_ref = 2'b00;

`ifdef SRAM_23K640_SLAVE_BACKDOOR_EN
  logic [7:0] bd_rdata;
`endif

  sram_23k640_slave dut (
    .i_clk      (clk),
    .i_rst      (rst),
    .i_sck      (sck),
    .i_cs       (cs),
    .i_si       (si),
`ifdef SRAM_23K640_SLAVE_BACKDOOR_EN
    .i_bd_we    (1'b0),
    .i_bd_addr  (13'd0),
    .i_bd_wdata (8'd0),
    .o_bd_rdata (bd_rdata),
`endif
    .o_so       (so),
    .o_mode     (mode),
    .o_busy     (busy)
  );

  always #5 clk = ~clk;

  function automatic int next_addr(input int a);
    if (mode_ref == 2'b10) return (a & ~31) | ((a + 1) & 31);
    return (a + 1) % 8192;
  endfunction

  function automatic void model_write(input logic [15:0] a0, input bq_t d);
    int a = int'(a0) % 8192;
    foreach (d[i]) begin
      mem_ref[a] = d[i];
      if (mode_ref == 2'b00 || mode_ref == 2'b11) break;
      a = next_addr(a);
    end
  endfunction

  function automatic bq_t model_read(input logic [15:0] a0, input int n);
    bq_t q;
    int a = int'(a0) % 8192;
    for (int i = 0; i < n; i++) begin
      if (i > 0 && (mode_ref == 2'b00 || mode_ref == 2'b11)) begin
        q.push_back(8'h00);
      end else begin
        q.push_back(mem_ref[a]);
        a = next_addr(a);
      end
    end
    return q;
  endfunction

  task automatic half();
    repeat (8) @(posedge clk);
    #1;
  endtask

  task automatic xfer(input logic [7:0] tx, output logic [7:0] rx);
    for (int b = 7; b >= 0; b--) begin
      si = tx[b];
      half();
      rx[b] = so;
      sck = 1'b1;
      half();
      sck = 1'b0;
    end
  endtask

  task automatic xfer_bits(input logic [7:0] tx, input int n);
    for (int b = 7; b >= 8 - n; b--) begin
      si = tx[b];
      half();
      sck = 1'b1;
      half();
      sck = 1'b0;
    end
  endtask

  task automatic cs_on();
    cs = 1'b0;
    half();
  endtask

  task automatic cs_off();
    half();
    cs = 1'b1;
    half();
    half();
  endtask

  task automatic do_write(input logic [15:0] a, input bq_t d);
    logic [7:0] r;
    cs_on();
    xfer(8'h02, r);
    xfer(a[15:8], r);
    xfer(a[7:0], r);
    foreach (d[i]) xfer(d[i], r);
    cs_off();
    model_write(a, d);
  endtask

  task automatic do_read(input logic [15:0] a, input int n, output bq_t q);
    logic [7:0] r;
    q = {};
    cs_on();
    xfer(8'h03, r);
    xfer(a[15:8], r);
    xfer(a[7:0], r);
    for (int i = 0; i < n; i++) begin
      xfer(8'($urandom), r);
      q.push_back(r);
    end
    cs_off();
  endtask

  task automatic do_wrsr(input logic [7:0] v);
    logic [7:0] r;
    cs_on();
    xfer(8'h01, r);
    xfer(v, r);
    cs_off();
    mode_ref = v[7:6];
  endtask

  task automatic do_rdsr(input int n, output bq_t q);
    logic [7:0] r;
    q = {};
    cs_on();
    xfer(8'h05, r);
    for (int i = 0; i < n; i++) begin
      xfer(8'($urandom), r);
      q.push_back(r);
    end
    cs_off();
  endtask

  task automatic test_reset();
    bq_t got;
    logic [7:0] r;
    n_tests++;
    if (so !== 1'b0) begin
      n_fail++; $display("FAIL reset_so got %b want 0", so);
    end
    n_tests++;
    if (busy !== 1'b0) begin
      n_fail++; $display("FAIL reset_busy got %b want 0", busy);
    end
    n_tests++;
    if (mode !== 2'b00) begin
      n_fail++; $display("FAIL reset_mode got %b want 00", mode);
    end
    cs_on();
    xfer(8'h05, r);
    n_tests++;
    if (busy !== 1'b1) begin
      n_fail++; $display("FAIL busy_in_cmd got %b want 1", busy);
    end
    got = {};
    for (int i = 0; i < 2; i++) begin
      xfer(8'h00, r);
      got.push_back(r);
    end
    cs_off();
    n_tests++;
    if (busy !== 1'b0) begin
      n_fail++; $display("FAIL busy_after_cs got %b want 0", busy);
    end
    foreach (got[i]) begin
      n_tests++;
      if (got[i] !== {mode_ref, 6'b000010}) begin
        n_fail++;
        $display("FAIL rdsr_reset[%0d] got %h want %h", i, got[i], {mode_ref, 6'b000010});
      end
    end
  endtask

  task automatic test_wrsr();
    bq_t got;
    do_wrsr(8'h40);
    n_tests++;
    if (mode !== mode_ref) begin
      n_fail++; $display("FAIL wrsr_mode got %b want %b", mode, mode_ref);
    end
    do_rdsr(2, got);
    foreach (got[i]) begin
      n_tests++;
      if (got[i] !== {mode_ref, 6'b000010}) begin
        n_fail++;
        $display("FAIL rdsr_after_wrsr[%0d] got %h want %h", i, got[i], {mode_ref, 6'b000010});
      end
    end
  endtask

  task automatic preload();
    bq_t d;
    do_wrsr(8'h40);
    d = {};
    for (int i = 0; i < 64; i++) d.push_back(8'($urandom));
    do_write(16'h0000, d);
    d = {};
    for (int i = 0; i < 4; i++) d.push_back(8'($urandom));
    do_write(16'h0100, d);
    d = {};
    for (int i = 0; i < 8; i++) d.push_back(8'($urandom));
    do_write(16'h1FF8, d);
  endtask

  task automatic test_seq();
    bq_t d, got, exp;
    do_wrsr(8'h40);
    d = '{8'hA5, 8'h5A, 8'hC3};
    do_write(16'h0010, d);
    do_read(16'h0010, 3, got);
    exp = model_read(16'h0010, 3);
    foreach (exp[i]) begin
      n_tests++;
      if (got[i] !== exp[i]) begin
        n_fail++; $display("FAIL seq_read[%0d] got %h want %h", i, got[i], exp[i]);
      end
    end
    do_read(16'hE010, 1, got);
    n_tests++;
    if (got[0] !== mem_ref[16'h0010]) begin
      n_fail++; $display("FAIL upper_addr_ignored got %h want %h", got[0], mem_ref[16'h0010]);
    end
  endtask

  task automatic test_byte();
    bq_t d, got, exp;
    do_wrsr(8'h00);
    d = '{8'h11, 8'h22};
    do_write(16'h0100, d);
    do_read(16'h0100, 2, got);
    exp = model_read(16'h0100, 2);
    foreach (exp[i]) begin
      n_tests++;
      if (got[i] !== exp[i]) begin
        n_fail++; $display("FAIL byte_read[%0d] got %h want %h", i, got[i], exp[i]);
      end
    end
    do_wrsr(8'hC0);
    d = '{8'h33, 8'h44};
    do_write(16'h0102, d);
    do_wrsr(8'h40);
    do_read(16'h0100, 4, got);
    exp = model_read(16'h0100, 4);
    foreach (exp[i]) begin
      n_tests++;
      if (got[i] !== exp[i]) begin
        n_fail++; $display("FAIL byte_check[%0d] got %h want %h", i, got[i], exp[i]);
      end
    end
  endtask

  task automatic test_page();
    bq_t d, got, exp;
    do_wrsr(8'h80);
    d = '{8'h77, 8'h88};
    do_write(16'h001F, d);
    do_read(16'h003E, 3, got);
    exp = model_read(16'h003E, 3);
    foreach (exp[i]) begin
      n_tests++;
      if (got[i] !== exp[i]) begin
        n_fail++; $display("FAIL page_read[%0d] got %h want %h", i, got[i], exp[i]);
      end
    end
    do_wrsr(8'h40);
    do_read(16'h001F, 2, got);
    exp = '{mem_ref[16'h001F], mem_ref[16'h0020]};
    foreach (exp[i]) begin
      n_tests++;
      if (got[i] !== exp[i]) begin
        n_fail++; $display("FAIL page_wrap_hi[%0d] got %h want %h", i, got[i], exp[i]);
      end
    end
    do_read(16'h0000, 1, got);
    n_tests++;
    if (got[0] !== mem_ref[0]) begin
      n_fail++; $display("FAIL page_wrap_lo got %h want %h", got[0], mem_ref[0]);
    end
    d = '{8'h5C, 8'hC5};
    do_write(16'h1FFF, d);
    do_read(16'h1FFF, 2, got);
    exp = model_read(16'h1FFF, 2);
    foreach (exp[i]) begin
      n_tests++;
      if (got[i] !== exp[i]) begin
        n_fail++; $display("FAIL seq_wrap[%0d] got %h want %h", i, got[i], exp[i]);
      end
    end
  endtask

  task automatic test_abort();
    bq_t got, d, exp;
    logic [7:0] r;
    do_wrsr(8'h40);
    cs_on();
    xfer(8'h02, r);
    xfer(8'h00, r);
    xfer(8'h20, r);
    xfer_bits(~mem_ref[16'h0020], 4);
    cs_off();
    n_tests++;
    if (so !== 1'b0 || busy !== 1'b0) begin
      n_fail++; $display("FAIL abort_idle got so=%b busy=%b want 0 0", so, busy);
    end
    do_read(16'h0020, 1, got);
    n_tests++;
    if (got[0] !== mem_ref[16'h0020]) begin
      n_fail++; $display("FAIL abort_mem got %h want %h", got[0], mem_ref[16'h0020]);
    end
    cs_on();
    xfer(8'h9F, r);
    for (int i = 0; i < 2; i++) begin
      xfer(8'hFF, r);
      n_tests++;
      if (r !== 8'h00) begin
        n_fail++; $display("FAIL ignore_so[%0d] got %h want 00", i, r);
      end
    end
    n_tests++;
    if (busy !== 1'b1) begin
      n_fail++; $display("FAIL ignore_busy got %b want 1", busy);
    end
    cs_off();
    n_tests++;
    if (mode !== mode_ref) begin
      n_fail++; $display("FAIL ignore_mode got %b want %b", mode, mode_ref);
    end
    d = '{8'h3C, 8'h96};
    do_write(16'h0021, d);
    do_read(16'h0020, 3, got);
    exp = model_read(16'h0020, 3);
    foreach (exp[i]) begin
      n_tests++;
      if (got[i] !== exp[i]) begin
        n_fail++; $display("FAIL after_ignore[%0d] got %h want %h", i, got[i], exp[i]);
      end
    end
  endtask

  task automatic test_random();
    bq_t d, got, exp;
    logic [15:0] a;
    int n;
    for (int k = 0; k < 6; k++) begin
      do_wrsr(($urandom_range(0, 1) == 0) ? 8'h40 : 8'h80);
      a = 16'($urandom_range(16'h0040, 16'h00F0));
      n = $urandom_range(1, 6);
      d = {};
      for (int i = 0; i < n; i++) d.push_back(8'($urandom));
      do_write(a, d);
      do_read(a, n, got);
      exp = model_read(a, n);
      foreach (exp[i]) begin
        n_tests++;
        if (got[i] !== exp[i]) begin
          n_fail++;
          $display("FAIL rand[%0d.%0d] a=%h mode=%b got %h want %h", k, i, a, mode_ref, got[i], exp[i]);
        end
      end
    end
  endtask

  initial begin
    repeat (5) @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    test_reset();
    test_wrsr();
    preload();
    test_seq();
    test_byte();
    test_page();
    test_abort();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
